// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared parameters and state encoding for the IF->ID pipeline register
package pipe_pkg;

  localparam int          ADDR_W_DEF      = 32;
  localparam int          INSTR_W_DEF     = 32;
  localparam int          STALL_CNT_W_DEF = 16;
  localparam logic [31:0] NOP_INSTR_DEF   = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } pipe_state_e;

endpackage

// File: rtl/pipe_skid_slot.sv
// rtl/pipe_skid_slot.sv - one valid+data holding slot with load/clear
module pipe_skid_slot #(
  parameter int           W       = 64,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] data
);

  // Clearing restores CLR_VAL so an empty slot presents a defined bubble, never stale data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= CLR_VAL;
    end else if (clear) begin
      valid <= 1'b0;
      data  <= CLR_VAL;
    end else if (load) begin
      valid <= 1'b1;
      data  <= d;
    end
  end

endmodule

// File: rtl/fetch_decode_pipe_reg.sv
// rtl/fetch_decode_pipe_reg.sv - IF->ID pipeline register with 2-slot skid buffer, flush and stall counter
module fetch_decode_pipe_reg
  import pipe_pkg::*;
#(
  parameter int                 ADDR_W      = ADDR_W_DEF,
  parameter int                 INSTR_W     = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR   = INSTR_W'(NOP_INSTR_DEF),
  parameter int                 STALL_CNT_W = STALL_CNT_W_DEF
) (
  input  logic                   Clk,
  input  logic                   Reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      PCAddResult,
  input  logic [INSTR_W-1:0]     instruction,
  input  logic                   flush,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ADDR_W-1:0]      PCAddResultOut,
  output logic [INSTR_W-1:0]     instructionOut,
  output logic [STALL_CNT_W-1:0] stall_cycles
);

  localparam int DW = ADDR_W + INSTR_W;

  pipe_state_e   state, state_n;
  logic          in_fire, out_fire;
  logic          main_load, main_clr, skid_load, skid_clr;
  logic [DW-1:0] main_d, main_data, skid_data;
  logic          main_valid, skid_valid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  // Flush overrides every other event, including a same-cycle accepted input beat.
  always_comb begin
    state_n   = state;
    main_load = 1'b0;
    main_clr  = 1'b0;
    skid_load = 1'b0;
    skid_clr  = 1'b0;
    main_d    = {PCAddResult, instruction};
    if (flush) begin
      state_n  = ST_EMPTY;
      main_clr = 1'b1;
      skid_clr = 1'b1;
    end else begin
      case (state)
        ST_EMPTY: begin
          if (in_fire) begin
            main_load = 1'b1;
            state_n   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (in_fire && out_fire) begin
            main_load = 1'b1;
          end else if (in_fire) begin
            skid_load = 1'b1;
            state_n   = ST_FULL;
          end else if (out_fire) begin
            main_clr = 1'b1;
            state_n  = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (out_fire && skid_valid) begin
            main_load = 1'b1;
            main_d    = skid_data;
            skid_clr  = 1'b1;
            state_n   = ST_ONE;
          end
        end
        default: begin
          main_clr = 1'b1;
          skid_clr = 1'b1;
          state_n  = ST_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state        <= ST_EMPTY;
      in_ready     <= 1'b1;
      stall_cycles <= '0;
    end else begin
      state    <= state_n;
      in_ready <= (state_n != ST_FULL);
      if (main_valid && !out_ready && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
    end
  end

  pipe_skid_slot #(
    .W       (DW),
    .CLR_VAL ({{ADDR_W{1'b0}}, NOP_INSTR})
  ) u_main (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (main_load),
    .clear (main_clr),
    .d     (main_d),
    .valid (main_valid),
    .data  (main_data)
  );

  pipe_skid_slot #(
    .W       (DW),
    .CLR_VAL ('0)
  ) u_skid (
    .clk   (Clk),
    .rst_n (Reset),
    .load  (skid_load),
    .clear (skid_clr),
    .d     ({PCAddResult, instruction}),
    .valid (skid_valid),
    .data  (skid_data)
  );

  assign out_valid      = main_valid;
  assign PCAddResultOut = main_data[DW-1:INSTR_W];
  assign instructionOut = main_data[INSTR_W-1:0];

endmodule
